// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST controller slice.
// Holds the sequencer state encoding, 2-input truth-table constants and
// small helpers that size the settle counter from the SETTLE parameter.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit i of each table is the expected gate output for input vector i,
  // with vec[1] = A and vec[0] = B.
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;

  // Value loaded into the settle counter so WAIT lasts exactly SETTLE cycles.
  function automatic int settle_load(input int settle);
    return (settle > 0) ? settle - 1 : 0;
  endfunction

  // Counter width able to hold settle_load(); never narrower than one bit.
  function automatic int settle_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Bus between the BIST controller and its surroundings: the start request,
// the vector/response pair shared with the gate under test, and the results.
// Macro GATE_BIST_FAILMAP_EN adds the per-vector fail_map result.
interface gate_bist_ctrl_if #(
  parameter int N_IN = 2
);

  localparam int VEC = 2 ** N_IN;
  localparam int CW  = $clog2(VEC + 1);

  logic            start;
  logic [N_IN-1:0] vec;
  logic            dut_y;
  logic            busy;
  logic            done;
  logic            pass;
  logic [CW-1:0]   err_cnt;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail;
`ifdef GATE_BIST_FAILMAP_EN
  logic [VEC-1:0]  fail_map;
`endif

`ifdef GATE_BIST_FAILMAP_EN
  modport master (
    input  start, dut_y,
    output vec, busy, done, pass, err_cnt, fail_valid, first_fail, fail_map
  );

  modport slave (
    output start, dut_y,
    input  vec, busy, done, pass, err_cnt, fail_valid, first_fail, fail_map
  );
`else
  modport master (
    input  start, dut_y,
    output vec, busy, done, pass, err_cnt, fail_valid, first_fail
  );

  modport slave (
    output start, dut_y,
    input  vec, busy, done, pass, err_cnt, fail_valid, first_fail
  );
`endif

endinterface

// File: rtl/gate_bist_settle_cnt.sv
// Loadable down-counter timing the settle phase between driving a vector
// and sampling the gate output. It holds at zero once it gets there.
module gate_bist_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load takes priority; otherwise count down while enabled and not yet zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a small combinational gate.
// Walks every input vector, lets the gate settle, samples its output and
// compares it against EXP_TABLE, then reports pass, error count and the
// first failing vector. Macro GATE_BIST_FAILMAP_EN adds a per-vector fail map.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int                    N_IN      = 2,
  parameter int                    SETTLE    = 1,
  parameter logic [(2**N_IN)-1:0]  EXP_TABLE = AND_TT
) (
  input logic               clk,
  input logic               rst,
  gate_bist_ctrl_if.master  bus
);

  localparam int              VEC       = 2 ** N_IN;
  localparam int              CW        = $clog2(VEC + 1);
  localparam int              CNT_W     = settle_width(SETTLE);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(settle_load(SETTLE));
  localparam logic [N_IN-1:0] LAST_VEC  = {N_IN{1'b1}};
  localparam bit              HAS_WAIT  = (SETTLE > 0);

  state_t          state;
  state_t          state_nxt;

  logic            accept;
  logic            sampling;
  logic            finishing;
  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_zero;
  logic            last_vec;
  logic            mismatch;

  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [CW-1:0]   err_q;
  logic            fail_valid_q;
  logic [N_IN-1:0] first_fail_q;
`ifdef GATE_BIST_FAILMAP_EN
  logic [VEC-1:0]  fail_map_q;
`endif

  assign last_vec = (vec_q == LAST_VEC);
  assign mismatch = sampling && (bus.dut_y != EXP_TABLE[vec_q]);

  gate_bist_settle_cnt #(
    .W (CNT_W)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (LOAD_VAL),
    .zero  (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero settle time skips WAIT entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = HAS_WAIT ? WAIT : SAMPLE;
      WAIT:    if (cnt_zero) state_nxt = SAMPLE;
      SAMPLE:  begin
        if (last_vec) begin
          state_nxt = DONE;
        end else begin
          state_nxt = HAS_WAIT ? WAIT : SAMPLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes for the datapath and the settle counter.
  always_comb begin
    accept    = 1'b0;
    sampling  = 1'b0;
    finishing = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        accept   = bus.start;
        cnt_load = bus.start && HAS_WAIT;
      end
      WAIT: begin
        cnt_dec = 1'b1;
      end
      SAMPLE: begin
        sampling = 1'b1;
        cnt_load = HAS_WAIT && !last_vec;
      end
      DONE: begin
        finishing = 1'b1;
      end
      default: begin
        accept = 1'b0;
      end
    endcase
  end

  // Vector counter and result registers; results persist until the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
`ifdef GATE_BIST_FAILMAP_EN
      fail_map_q   <= '0;
`endif
    end else begin
      if (accept) begin
        vec_q        <= '0;
        busy_q       <= 1'b1;
        done_q       <= 1'b0;
        pass_q       <= 1'b0;
        err_q        <= '0;
        fail_valid_q <= 1'b0;
        first_fail_q <= '0;
`ifdef GATE_BIST_FAILMAP_EN
        fail_map_q   <= '0;
`endif
      end
      if (sampling) begin
        if (mismatch) begin
          err_q <= err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_valid_q <= 1'b1;
            first_fail_q <= vec_q;
          end
`ifdef GATE_BIST_FAILMAP_EN
          fail_map_q[vec_q] <= 1'b1;
`endif
        end
        if (!last_vec) begin
          vec_q <= vec_q + 1'b1;
        end
      end
      if (finishing) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        pass_q <= (err_q == '0);
        vec_q  <= '0;
      end
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.first_fail = first_fail_q;
`ifdef GATE_BIST_FAILMAP_EN
  assign bus.fail_map   = fail_map_q;
`endif

endmodule
